kred_mult_pipe: RTL and testbench

Pipelined, parametrised modular multiplier computing `(a * b) mod Q` with Barrett reduction, a valid/ready handshake on both sides and a pass-through tag. It is the streaming successor to the single-cycle ML-KEM coefficient multiplier. It sits between the twiddle-factor ROM/coefficient buffers and the NTT butterfly datapath, accepting one product per cycle at full throughput.

---
 rtl/kred_mult_pipe.sv | 134 +++++++++++++
 tb/tb_kred_mult_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kred_mult_pipe.sv
// rtl/kred_mult_pipe.sv - four-stage Barrett modular multiplier (a*b) mod Q with valid/ready and tag
// Optional build macro: KRED_MULT_RANGE_CHECK_EN (flags operands >= Q on out_err)
module kred_mult_pipe #(
   parameter int              W     = 12,
   parameter int unsigned     Q     = 3329,
   parameter int              K     = 2 * W,
   parameter longint unsigned M     = (64'd1 << K) / Q,
   parameter int              TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     c_mod_q,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   // p is 2W bits wide, p*M needs 2W+K bits, and the uncorrected
   // remainder is below 3Q so W+2 bits hold it.
   localparam int PW = 2 * W;
   localparam int MW = PW + K;
   localparam int RW = W + 2;

   logic             v1, v2, v3, v4;
   logic [W-1:0]     a1, b1;
   logic [TAG_W-1:0] tag1, tag2, tag3;
   logic             err1, err2, err3, err4;
   logic [PW-1:0]    p2;
   logic [RW-1:0]    r0_3;
   logic             err_in;
   logic             adv;

   logic [MW-1:0]    pm;
   logic [PW-1:0]    t_est;
   logic [PW-1:0]    tq;
   logic [RW-1:0]    r0_next;
   logic [RW-1:0]    r1;
   logic [RW-1:0]    r2;

   // The whole pipe moves together; only a held output blocks it.
   assign adv       = !(v4 && !out_ready);
   assign in_ready  = adv;
   assign out_valid = v4;
   assign out_err   = err4;

`ifdef KRED_MULT_RANGE_CHECK_EN
   assign err_in = (a >= W'(Q)) || (b >= W'(Q));
`else
   assign err_in = 1'b0;
`endif

   // S1: capture operands, tag and range flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         tag1 <= '0;
         err1 <= 1'b0;
      end else if (adv) begin
         v1   <= in_valid;
         a1   <= a;
         b1   <= b;
         tag1 <= in_tag;
         err1 <= err_in;
      end
   end

   // S2: full-width product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         p2   <= '0;
         tag2 <= '0;
         err2 <= 1'b0;
      end else if (adv) begin
         v2   <= v1;
         p2   <= PW'(a1) * PW'(b1);
         tag2 <= tag1;
         err2 <= err1;
      end
   end

   // Barrett quotient estimate and uncorrected remainder (estimate may be low by up to 2)
   always_comb begin
      pm      = MW'(p2) * MW'(M);
      t_est   = PW'(pm >> K);
      tq      = t_est * PW'(Q);
      r0_next = RW'(p2 - tq);
   end

   // S3: register uncorrected remainder
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3   <= 1'b0;
         r0_3 <= '0;
         tag3 <= '0;
         err3 <= 1'b0;
      end else if (adv) begin
         v3   <= v2;
         r0_3 <= r0_next;
         tag3 <= tag2;
         err3 <= err2;
      end
   end

   // Two conditional subtractions bring the remainder into [0, Q-1]
   always_comb begin
      r1 = (r0_3 >= RW'(Q)) ? r0_3 - RW'(Q) : r0_3;
      r2 = (r1 >= RW'(Q)) ? r1 - RW'(Q) : r1;
   end

   // S4: output register, held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v4      <= 1'b0;
         c_mod_q <= '0;
         out_tag <= '0;
         err4    <= 1'b0;
      end else if (adv) begin
         v4      <= v3;
         c_mod_q <= W'(r2);
         out_tag <= tag3;
         err4    <= err3;
      end
   end

endmodule

// File: tb/tb_kred_mult_pipe.sv
// tb/tb_kred_mult_pipe.sv - self-checking bench for kred_mult_pipe (default and W=14 builds)
module tb_kred_mult_pipe;

   localparam int          W1 = 12;
   localparam int unsigned Q1 = 3329;
   localparam int          W2 = 14;
   localparam int unsigned Q2 = 12289;

`ifdef KRED_MULT_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [7:0]  tag;
      logic [11:0] exp_c;
      logic        oor;
   } vec_t;

   typedef struct {
      longint c;
      longint tag;
      logic   err;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, out_err;
   logic [W1-1:0] a, b, c_mod_q;
   logic [7:0]    in_tag, out_tag;

   logic          in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
   logic [W2-1:0] a2, b2, c_mod_q2;
   logic [7:0]    in_tag2, out_tag2;

   int checks   = 0;
   int failures = 0;
   int out_cnt  = 0;
   int out_cnt2 = 0;

   exp_t sb1[$];
   exp_t sb2[$];

   kred_mult_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .c_mod_q(c_mod_q),
      .out_tag(out_tag), .out_err(out_err)
   );

   kred_mult_pipe #(.W(W2), .Q(Q2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2), .in_tag(in_tag2),
      .out_valid(out_valid2), .out_ready(out_ready2), .c_mod_q(c_mod_q2),
      .out_tag(out_tag2), .out_err(out_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard for the default instance: push on input transfer, pop on output transfer
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb1.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = sb1.pop_front();
            check("sb_c_mod_q", longint'(c_mod_q), e.c);
            check("sb_out_tag", longint'(out_tag), e.tag);
            check("sb_out_err", longint'(out_err), longint'(e.err));
            out_cnt++;
         end
      end
      if (rst_n && in_valid && in_ready) begin
         e.c   = (longint'(a) * longint'(b)) % longint'(Q1);
         e.tag = longint'(in_tag);
         e.err = RC & ((a >= W1'(Q1)) || (b >= W1'(Q1)));
         sb1.push_back(e);
      end
   end

   // Scoreboard for the W=14 instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid2 && out_ready2) begin
         if (sb2.size() == 0) begin
            check("unexpected_output2", 1, 0);
         end else begin
            e = sb2.pop_front();
            check("sweep_c_mod_q", longint'(c_mod_q2), e.c);
            check("sweep_out_tag", longint'(out_tag2), e.tag);
            check("sweep_out_err", longint'(out_err2), longint'(e.err));
            out_cnt2++;
         end
      end
      if (rst_n && in_valid2 && in_ready2) begin
         e.c   = (longint'(a2) * longint'(b2)) % longint'(Q2);
         e.tag = longint'(in_tag2);
         e.err = RC & ((a2 >= W2'(Q2)) || (b2 >= W2'(Q2)));
         sb2.push_back(e);
      end
   end

   // Present one vector and verify its result appears exactly 4 cycles later
   task automatic apply_vec(input vec_t v, input string name);
      int cyc;
      in_valid = 1'b1;
      a        = v.a;
      b        = v.b;
      in_tag   = v.tag;
      cyc      = 0;
      while (cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) in_valid = 1'b0;
         if (out_valid) break;
      end
      check({name, "_latency"}, cyc, 4);
      check({name, "_c"}, longint'(c_mod_q), longint'(v.exp_c));
      check({name, "_tag"}, longint'(out_tag), longint'(v.tag));
      check({name, "_err"}, longint'(out_err), longint'(RC & v.oor));
   endtask

   task automatic stream16();
      logic [11:0] sa[16];
      logic [11:0] sbv[16];
      logic [11:0] held;
      logic        acc;
      int idx, cyc, base, bound;
      for (int i = 0; i < 16; i++) begin
         sa[i]  = 12'($urandom_range(0, 4095));
         sbv[i] = 12'($urandom_range(0, 4095));
      end
      base = out_cnt;
      idx  = 0;
      cyc  = 0;
      held = '0;
      while (idx < 16 && cyc < 100) begin
         out_ready = !(cyc >= 6 && cyc <= 9);
         in_valid  = 1'b1;
         a         = sa[idx];
         b         = sbv[idx];
         in_tag    = 8'(idx);
         @(negedge clk);
         check("stall_in_ready", longint'(in_ready), longint'(!(cyc >= 6 && cyc <= 9)));
         if (cyc == 6) held = c_mod_q;
         if (cyc > 6 && cyc <= 9) check("stall_hold", longint'(c_mod_q), longint'(held));
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      bound = 0;
      while (sb1.size() != 0 && bound < 50) begin
         @(posedge clk);
         #1;
         bound++;
      end
      check("stream_accepted", idx, 16);
      check("stream_drained", sb1.size(), 0);
      check("stream_out_count", out_cnt - base, 16);
   endtask

   task automatic reset_mid();
      vec_t v;
      int   seen;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = 12'(100 + i);
         b        = 12'(7 + i);
         in_tag   = 8'(8'h40 + i);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", longint'(out_valid), 0);
      check("rst_mid_c_mod_q", longint'(c_mod_q), 0);
      check("rst_mid_out_tag", longint'(out_tag), 0);
      sb1.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst_no_stale", seen, 0);
      @(posedge clk);
      #1;
      v = '{a: 12'd33, b: 12'd101, tag: 8'h77, exp_c: 12'd4, oor: 1'b0};
      apply_vec(v, "post_reset");
   endtask

   task automatic sweep();
      logic acc;
      int idx, cyc, bound;
      idx = 0;
      cyc = 0;
      while (idx < 10000 && cyc < 40000) begin
         out_ready2 = ($urandom_range(0, 9) != 0);
         in_valid2  = 1'b1;
         a2         = W2'($urandom_range(0, 16383));
         b2         = W2'($urandom_range(0, 16383));
         if (idx % 50 == 0) a2 = W2'(Q2 - 1);
         in_tag2    = 8'(idx);
         @(negedge clk);
         acc = in_ready2;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid2  = 1'b0;
      out_ready2 = 1'b1;
      bound = 0;
      while (sb2.size() != 0 && bound < 50) begin
         @(posedge clk);
         #1;
         bound++;
      end
      check("sweep_accepted", idx, 10000);
      check("sweep_drained", sb2.size(), 0);
      check("sweep_out_count", out_cnt2, 10000);
   endtask

   initial begin
      vec_t tbl[7];
      tbl[0] = '{a: 12'd10,   b: 12'd5,    tag: 8'h01, exp_c: 12'd50,   oor: 1'b0};
      tbl[1] = '{a: 12'd4095, b: 12'd2,    tag: 8'h02, exp_c: 12'd1532, oor: 1'b1};
      tbl[2] = '{a: 12'd3328, b: 12'd3328, tag: 8'h03, exp_c: 12'd1,    oor: 1'b0};
      tbl[3] = '{a: 12'd2048, b: 12'd2048, tag: 8'h04, exp_c: 12'd3093, oor: 1'b0};
      tbl[4] = '{a: 12'd0,    b: 12'd3328, tag: 8'h05, exp_c: 12'd0,    oor: 1'b0};
      tbl[5] = '{a: 12'd4095, b: 12'd4095, tag: 8'h06, exp_c: 12'd852,  oor: 1'b1};
      tbl[6] = '{a: 12'd3329, b: 12'd1,    tag: 8'h07, exp_c: 12'd0,    oor: 1'b1};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      in_tag     = '0;
      out_ready  = 1'b1;
      in_valid2  = 1'b0;
      a2         = '0;
      b2         = '0;
      in_tag2    = '0;
      out_ready2 = 1'b1;
      #3;
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_c_mod_q", longint'(c_mod_q), 0);
      check("reset_out_tag", longint'(out_tag), 0);
      check("reset_out_err", longint'(out_err), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_ready", longint'(in_ready), 1);

      for (int i = 0; i < 7; i++) begin
         apply_vec(tbl[i], $sformatf("vec%0d", i));
      end
      @(posedge clk);
      #1;

      stream16();
      reset_mid();
      @(posedge clk);
      #1;
      sweep();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
